// File: rtl/score_ctrl_pkg.sv
// rtl/score_ctrl_pkg.sv - shared constants and BCD step helper for the scoreboard controller
package score_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_IDX_W  = 2;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;

  // Steps digit idx by +/-1; with cascade set, a wrap ripples into the next digit up.
  // Anything leaving digit 3 is dropped, so the score wraps 9999 <-> 0000.
  function automatic logic [4*NUM_DIGITS-1:0] bcd_step(
    input logic [4*NUM_DIGITS-1:0] num,
    input logic [DIG_IDX_W-1:0]    idx,
    input logic                    dec,
    input logic                    cascade
  );
    logic [4*NUM_DIGITS-1:0] res;
    logic [3:0]              dig;
    logic                    active;
    res    = num;
    active = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dig = num[d*4 +: 4];
      if (d == int'(idx)) active = 1'b1;
      if (active) begin
        if (dec) begin
          if (dig == DIGIT_MIN) begin
            res[d*4 +: 4] = DIGIT_MAX;
          end else begin
            res[d*4 +: 4] = dig - 4'd1;
            active        = 1'b0;
          end
        end else begin
          if (dig == DIGIT_MAX) begin
            res[d*4 +: 4] = DIGIT_MIN;
          end else begin
            res[d*4 +: 4] = dig + 4'd1;
            active        = 1'b0;
          end
        end
        if (!cascade) active = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_ctrl_btn_debounce.sv
// rtl/score_ctrl_btn_debounce.sv - per-button synchroniser, debounce counter and press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      // The level only flips after DB_CYCLES consecutive differing samples.
      if (r_sync2 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= ~r_db;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - button-driven 4-digit BCD score with arbitration and digit blink mask
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 16,
  parameter int BLINK_CYCLES = 8,
  parameter int CARRY        = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_DIGITS-1:0]   i_btn,
  input  logic                    i_dec,
  input  logic                    i_clr,
  output logic [4*NUM_DIGITS-1:0] o_num,
  output logic [NUM_DIGITS-1:0]   o_le_mask,
  output logic                    o_upd,
  output logic                    o_busy
);

  localparam int BC_W = $clog2(BLINK_CYCLES + 1);

  logic [NUM_DIGITS-1:0]   w_press;
  logic [NUM_DIGITS-1:0]   w_served;
  logic [DIG_IDX_W-1:0]    w_idx;
  logic                    w_serve;
  logic [NUM_DIGITS-1:0]   w_pending_next;
  logic [4*NUM_DIGITS-1:0] w_num_next;

  logic [NUM_DIGITS-1:0]   r_pending;
  logic [4*NUM_DIGITS-1:0] r_num;
  logic [NUM_DIGITS-1:0]   r_le_mask;
  logic [BC_W-1:0]         r_blink_cnt;
  logic                    r_upd;
  logic                    r_busy;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn[g]),
      .o_press (w_press[g])
    );
  end

  // Fixed priority: scanning downward lets the lowest pending index win.
  always_comb begin
    w_served = '0;
    w_idx    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_served    = '0;
        w_served[i] = 1'b1;
        w_idx       = DIG_IDX_W'(i);
      end
    end
  end

  assign w_serve        = (|r_pending) & ~i_clr;
  assign w_pending_next = i_clr ? '0 : ((r_pending & ~w_served) | w_press);
  assign w_num_next     = bcd_step(r_num, w_idx, i_dec, CARRY != 0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending   <= '0;
      r_busy      <= 1'b0;
      r_num       <= '0;
      r_le_mask   <= '0;
      r_blink_cnt <= '0;
      r_upd       <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_busy    <= |w_pending_next;
      if (i_clr) begin
        r_num       <= '0;
        r_le_mask   <= '0;
        r_blink_cnt <= '0;
        r_upd       <= 1'b0;
      end else if (w_serve) begin
        r_num       <= w_num_next;
        r_le_mask   <= w_served;
        r_blink_cnt <= BC_W'(BLINK_CYCLES);
        r_upd       <= 1'b1;
      end else begin
        r_upd <= 1'b0;
        if (r_blink_cnt != '0) begin
          r_blink_cnt <= r_blink_cnt - 1'b1;
          if (r_blink_cnt == BC_W'(1)) r_le_mask <= '0;
        end
      end
    end
  end

  assign o_num     = r_num;
  assign o_le_mask = r_le_mask;
  assign o_upd     = r_upd;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - directed bench for score_ctrl, cascaded and per-digit modes side by side
module tb_score_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn = 4'b0;
  logic        dec = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] num_c, num_n;
  logic [3:0]  le_c, le_n;
  logic        upd_c, upd_n, busy_c, busy_n;

  int checks = 0;
  int errors = 0;
  int upd_total = 0;
  int upd_total_n = 0;

  always #5 clk = ~clk;

  score_ctrl #(.DB_CYCLES(4), .BLINK_CYCLES(8), .CARRY(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_dec(dec), .i_clr(clr),
    .o_num(num_c), .o_le_mask(le_c), .o_upd(upd_c), .o_busy(busy_c)
  );

  score_ctrl #(.DB_CYCLES(4), .BLINK_CYCLES(8), .CARRY(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_dec(dec), .i_clr(clr),
    .o_num(num_n), .o_le_mask(le_n), .o_upd(upd_n), .o_busy(busy_n)
  );

  typedef struct {
    logic        pre_clr;
    logic [3:0]  btn;
    logic        dec;
    logic [15:0] exp_c;
    logic [15:0] exp_n;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (upd_c) upd_total++;
    if (upd_n) upd_total_n++;
  endtask

  task automatic press(input logic [3:0] m, input logic d);
    btn = m;
    dec = d;
    repeat (12) tick();
    btn = 4'b0;
    repeat (10) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    int u0, un0, k, busy_seen, mask_cnt, upd_at, mask_first;
    int npulse, t1, t2, busy_cnt;
    logic [15:0] first_num, second_num;
    logic [3:0]  le_second;

    vecs[0] = '{1'b1, 4'b0010, 1'b0, 16'h0010, 16'h0010};
    vecs[1] = '{1'b0, 4'b0001, 1'b1, 16'h0009, 16'h0019};
    vecs[2] = '{1'b0, 4'b0001, 1'b0, 16'h0010, 16'h0010};
    vecs[3] = '{1'b1, 4'b0001, 1'b1, 16'h9999, 16'h0009};
    vecs[4] = '{1'b0, 4'b1000, 1'b0, 16'h0999, 16'h1009};
    vecs[5] = '{1'b0, 4'b0001, 1'b0, 16'h1000, 16'h1000};
    vecs[6] = '{1'b1, 4'b0001, 1'b1, 16'h9999, 16'h0009};
    vecs[7] = '{1'b0, 4'b0001, 1'b0, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 4'b0100, 1'b1, 16'h9900, 16'h0900};
    vecs[9] = '{1'b0, 4'b1001, 1'b0, 16'h0901, 16'h1901};

    // Reset values, then bounce rejection on btn[0].
    repeat (3) tick();
    check("reset num", num_c, 16'h0000);
    check("reset le_mask", le_c, 4'b0000);
    check("reset upd", upd_c, 1'b0);
    check("reset busy", busy_c, 1'b0);
    rst = 1'b1;
    tick();
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ((i % 2) == 0) btn[0] = ~btn[0];
      tick();
      if (busy_c) busy_seen++;
    end
    btn = 4'b0;
    repeat (10) tick();
    check("bounce num", num_c, 16'h0000);
    check("bounce upd count", upd_total, 0);
    check("bounce busy", busy_seen, 0);
    check("bounce le_mask", le_c, 4'b0000);

    // Single press on digit 1 and its blink window.
    u0 = upd_total; mask_cnt = 0; upd_at = -1; mask_first = -1;
    btn = 4'b0010; dec = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) btn = 4'b0;
      tick();
      if (upd_c && upd_at < 0) upd_at = i;
      if (le_c == 4'b0010) begin
        mask_cnt++;
        if (mask_first < 0) mask_first = i;
      end
    end
    check("single num", num_c, 16'h0010);
    check("single upd count", upd_total - u0, 1);
    check("single mask cycles", mask_cnt, 8);
    check("single mask starts with upd", mask_first, upd_at);
    check("single mask end", le_c, 4'b0000);

    // Simultaneous presses on digits 3 and 0.
    do_clr();
    npulse = 0; t1 = -1; t2 = -1; busy_cnt = 0;
    first_num = 16'hffff; second_num = 16'hffff; le_second = 4'hf;
    btn = 4'b1001; dec = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 12) btn = 4'b0;
      tick();
      if (busy_c) busy_cnt++;
      if (upd_c) begin
        if (npulse == 0) begin first_num = num_c; t1 = i; end
        else begin second_num = num_c; t2 = i; le_second = le_c; end
        npulse++;
      end
    end
    check("arb busy cycles", busy_cnt, 2);
    check("arb upd pulses", npulse, 2);
    check("arb first num", first_num, 16'h0001);
    check("arb second num", second_num, 16'h1001);
    check("arb consecutive", t2 - t1, 1);
    check("arb final le_mask", le_second, 4'b1000);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].pre_clr) do_clr();
      u0 = upd_total; un0 = upd_total_n;
      press(vecs[v].btn, vecs[v].dec);
      check($sformatf("vec%0d num carry", v), num_c, vecs[v].exp_c);
      check($sformatf("vec%0d num nocarry", v), num_n, vecs[v].exp_n);
      check($sformatf("vec%0d upd count", v), upd_total - u0, $countones(vecs[v].btn));
      check($sformatf("vec%0d upd count nocarry", v), upd_total_n - un0, $countones(vecs[v].btn));
    end

    // clr lands in the cycle a pending request would be served.
    u0 = upd_total;
    btn = 4'b0001; dec = 1'b0; k = 0;
    while (!busy_c && k < 20) begin tick(); k++; end
    check("clr wait busy", busy_c, 1'b1);
    clr = 1'b1;
    tick();
    check("clr num", num_c, 16'h0000);
    check("clr busy", busy_c, 1'b0);
    check("clr upd", upd_c, 1'b0);
    check("clr num nocarry", num_n, 16'h0000);
    clr = 1'b0;
    repeat (10) tick();
    btn = 4'b0;
    repeat (10) tick();
    check("clr no late update", upd_total - u0, 0);
    check("clr num after", num_c, 16'h0000);

    // Asynchronous reset while a request is pending and a digit blinks.
    btn = 4'b0100; k = 0;
    while (!upd_c && k < 20) begin tick(); k++; end
    check("rst pre num", num_c, 16'h0100);
    btn = 4'b0101; k = 0;
    while (!busy_c && k < 20) begin tick(); k++; end
    check("rst pre busy", busy_c, 1'b1);
    check("rst pre le_mask", le_c, 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    check("rst num", num_c, 16'h0000);
    check("rst le_mask", le_c, 4'b0000);
    check("rst busy", busy_c, 1'b0);
    check("rst upd", upd_c, 1'b0);
    btn = 4'b0;
    u0 = upd_total;
    repeat (3) tick();
    rst = 1'b1;
    repeat (12) tick();
    check("rst discards pending", upd_total - u0, 0);
    check("rst num after", num_c, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Sequencing controller for the 4-digit scoreboard display path.
- Takes raw push-buttons and does synchronisation, debounce and one-pulse on each.
- Arbitrates simultaneous presses and applies each one as a ±1 update to a 4-digit BCD score, with optional carry between digits.
- Drives the 16-bit number and a digit-blink mask into the existing 7-segment display driver.

Parameters:
- DB_CYCLES, 16, consecutive stable samples before a button level is accepted (use 4 in simulation).
- BLINK_CYCLES, 8, cycles the last-updated digit's mask bit stays high.
- CARRY, 1, 1 = cascaded decimal counter (button i adds ±10^i); 0 = each digit wraps on its own.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btn  in  4  raw buttons, active-high, asynchronous to clk; btn[i] selects digit i (digit 0 = num[3:0]).
- dec  in  1  level input; 1 = decrement, 0 = increment; sampled when a request is served.
- clr  in  1  synchronous clear, active-high.
- num  out 16  BCD score, 4 digits, num[15:12] most significant.
- le_mask  out 4  blink mask for the display driver; bit i high = digit i blinking.
- upd  out 1  one-cycle pulse in the cycle after num changes because of a button.
- busy  out 1  high while any request is pending.

Behaviour:
- Reset (rst=0, asynchronous): num=0, le_mask=0, upd=0, busy=0, pending=0.
- Reset also clears sync flops, debounce counters and debounced levels to 0.
- Reset mid-operation discards all pending and in-flight presses.
- Input path, per button:
  - 2-flop synchroniser.
  - Counter compares the synchronised sample with the debounced level db[i].
  - Counter reaches DB_CYCLES-1 with a differing sample → db[i] toggles next cycle and the counter clears.
  - Any matching sample → counter clears.
- Press detect: press[i] = db[i] & ~db_q[i], one cycle wide. Releases produce nothing.
- pending[3:0] register: pending_next = (pending & ~served) | press.
  - A press on a bit that is already pending merges (it is lost, not counted twice).
  - A press in the same cycle its bit is served re-sets the bit.
- Arbiter: each cycle with pending≠0, serve the lowest set index i (fixed priority, digit 0 highest).
- Exactly one update per cycle. Latency: press at cycle T → pending at T+1 → num updated at T+2 if bit i is the lowest pending.
- Update with CARRY=1:
  - Increment: digit i +1; 9→0 ripples carry to digit i+1 and upward within the same cycle.
  - Decrement: 0→9 ripples borrow upward.
  - Carry out of digit 3 is dropped: 9999+1 → 0000, 0000−1 → 9999.
  - Digits below i are untouched.
- Update with CARRY=0: only digit i changes, wrapping 9→0 on increment and 0→9 on decrement.
- Non-BCD digit values are unreachable; no handling required.
- upd: pulses high the cycle after any served update.
- le_mask:
  - On a served update it becomes one-hot (1<<i) and a blink counter loads BLINK_CYCLES.
  - It clears to 0 when the counter expires.
  - A new update before expiry replaces the mask and reloads the counter.
- busy = (pending≠0), registered.
- clr=1 for one or more cycles: next edge sets num=0, pending=0, le_mask=0, upd=0.
  - Presses arriving while clr=1 are discarded.
  - Debounce state is not cleared.
  - clr has priority over serving a request in the same cycle.
- dec changes mid-burst: each request uses dec as sampled in its own serve cycle.

Decomposition:
- Shared package holds:
  - BCD constants DIGIT_MAX=4'd9 and DIGIT_MIN=4'd0.
  - NUM_DIGITS=4.
  - Digit-index width 2.
  - A BCD ±1-with-carry function used by both CARRY modes.
- One sub-module, btn_debounce (per-button synchroniser, counter and edge pulse, parameter DB_CYCLES), instantiated 4×.
- Arbiter, update datapath and blink timer stay in score_ctrl.

Test Plan:
- Reset values and bounce rejection:
  - Stimulus: rst low then high; toggle btn[0] every 2 cycles for 20 cycles (DB_CYCLES=4).
  - Response: num=16'h0000, le_mask=0, upd never pulses.
- Single press: btn[1] held high 10 cycles with dec=0, starting from 0000 → num=16'h0010, one upd pulse, le_mask=4'b0010 for 8 cycles then 0.
- Carry and wrap:
  - num=0999, CARRY=1, press btn[0] → 1000.
  - num=9999, press btn[0] → 0000.
  - dec=1 at 0000, press btn[0] → 9999.
  - CARRY=0 with digit0=9, press btn[0] → digit0=0, other digits unchanged.
- Arbitration:
  - btn[3] and btn[0] rise together, debounced in the same cycle, from 0000.
  - Response: busy high 2 cycles; num goes 0001 then 1001 on consecutive cycles; two upd pulses; final le_mask=4'b1000.
- Clear priority:
  - Pending request outstanding and clr=1 in the cycle it would be served → num=0000, pending=0, busy=0, no upd.
  - Async rst pulse mid-press → all outputs 0 immediately.
